sico_stream_tap: RTL and testbench

- Passive tap on a valid/ready link. Sits directly upstream of SiCoRecorder and drives its val_i input.
- SiCoRecorder records only on a value change, so back-to-back identical beats on the link would be lost.
- This block buffers each accepted beat and re-emits it as a held word {seq, data}. A rolling sequence field guarantees that every beat produces a distinct change.
- Beats are paced so each record word is stable for at least HOLD clock cycles.

---
 rtl/sico_stream_tap.sv | 124 ++++++++++++
 tb/tb_sico_stream_tap.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sico_stream_tap.sv
// -----------------------------------------------------------------------------
// sico_stream_tap
//
// Passive tap on a valid/ready link that feeds a change-triggered recorder.
// Each accepted beat is buffered in a small FIFO and re-emitted as a held
// record word {seq, data}. The seq field advances on every emitted word, so
// back-to-back identical beats still appear as distinct changes downstream.
// Emission is paced so every record word stays stable for at least HOLD
// cycles.
//
// Ports
//   clk_i        : clock, all state updates on the rising edge
//   reset_i      : synchronous, active-high reset
//   en_i         : capture enable (draining continues when low)
//   tap_valid_i  : valid of the observed link
//   tap_ready_i  : ready of the observed link
//   tap_data_i   : data of the observed link
//   rec_val_o    : record word {seq, data}, seq in the MSBs
//   pending_o    : FIFO non-empty after the current edge
//   overflow_o   : sticky, set when any beat is dropped
//   drop_cnt_o   : saturating count of dropped beats
// -----------------------------------------------------------------------------
module sico_stream_tap #(
    parameter int WIDTH = 8,
    parameter int SEQ_W = 4,
    parameter int DEPTH = 8,
    parameter int HOLD  = 1,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    input  logic                   tap_valid_i,
    input  logic                   tap_ready_i,
    input  logic [WIDTH-1:0]       tap_data_i,
    output logic [SEQ_W+WIDTH-1:0] rec_val_o,
    output logic                   pending_o,
    output logic                   overflow_o,
    output logic [CNT_W-1:0]       drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic [SEQ_W-1:0] seq;
    logic [SEQ_W-1:0] seq_inc;
    logic [HW-1:0]    hold_cnt;

    logic empty;
    logic full;
    logic capture;
    logic pop;
    logic push;
    logic drop;

    // NOTE: every signal assigned here is fully specified on every path, so
    // no latch can be inferred.
    always_comb begin
        empty      = (wr_ptr == rd_ptr);
        full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        capture    = en_i && tap_valid_i && tap_ready_i;
        // Pop looks at occupancy before this edge's push: no same-edge bypass.
        pop        = !empty && (hold_cnt == '0);
        // A pop frees a slot at the same edge, so a full FIFO still accepts.
        push       = capture && (!full || pop);
        drop       = capture && full && !pop;
        wr_ptr_nxt = wr_ptr + (AW + 1)'(push);
        rd_ptr_nxt = rd_ptr + (AW + 1)'(pop);
        seq_inc    = seq + SEQ_W'(1);
    end

    // NOTE: the storage array has no reset; validity is tracked entirely by
    // the pointers, and leaving it unreset keeps it mappable to plain RAM.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= tap_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so that the read
    // of mem at the head sees the pre-edge contents even when a push writes
    // the same slot (full FIFO with simultaneous push and pop).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            seq        <= '0;
            hold_cnt   <= '0;
            rec_val_o  <= '0;
            pending_o  <= 1'b0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            pending_o <= (wr_ptr_nxt != rd_ptr_nxt);

            if (pop) begin
                seq       <= seq_inc;
                rec_val_o <= {seq_inc, mem[rd_ptr[AW-1:0]]};
                hold_cnt  <= HOLD_RELOAD;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end

            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != '1) begin
                    drop_cnt_o <= drop_cnt_o + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sico_stream_tap.sv
// -----------------------------------------------------------------------------
// tb_sico_stream_tap
//
// Directed bench for sico_stream_tap. Three instances share clock, reset,
// enable, ready and data, each with its own valid:
//   dut1 : HOLD=1 (single beat, identical repeats, enable gating, seq wrap)
//   dut3 : HOLD=3 (pacing)
//   dut4 : HOLD=4, DEPTH=8, CNT_W=2 (overflow, saturation, reset mid-burst)
// -----------------------------------------------------------------------------
module tb_sico_stream_tap;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       ready;
    logic [7:0] data;
    logic       v1, v3, v4;

    logic [11:0] rec1, rec3, rec4;
    logic        pend1, pend3, pend4;
    logic        ovf1, ovf3, ovf4;
    logic [15:0] drop1, drop3;
    logic [1:0]  drop4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sico_stream_tap #(.WIDTH(8), .SEQ_W(4), .DEPTH(8), .HOLD(1), .CNT_W(16)) dut1 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .tap_valid_i(v1), .tap_ready_i(ready),
        .tap_data_i(data), .rec_val_o(rec1), .pending_o(pend1), .overflow_o(ovf1),
        .drop_cnt_o(drop1)
    );

    sico_stream_tap #(.WIDTH(8), .SEQ_W(4), .DEPTH(8), .HOLD(3), .CNT_W(16)) dut3 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .tap_valid_i(v3), .tap_ready_i(ready),
        .tap_data_i(data), .rec_val_o(rec3), .pending_o(pend3), .overflow_o(ovf3),
        .drop_cnt_o(drop3)
    );

    sico_stream_tap #(.WIDTH(8), .SEQ_W(4), .DEPTH(8), .HOLD(4), .CNT_W(2)) dut4 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .tap_valid_i(v4), .tap_ready_i(ready),
        .tap_data_i(data), .rec_val_o(rec4), .pending_o(pend4), .overflow_o(ovf4),
        .drop_cnt_o(drop4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One rising edge, then settle 1 time unit past it before driving/sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Overflow scenario: retained beats are 1..11 then 14 (12 and 13 dropped).
    function automatic logic [11:0] ovf_expect(input int idx);
        logic [7:0] d;
        d = (idx < 11) ? 8'(idx + 1) : 8'd14;
        return {4'(idx + 1), d};
    endfunction

    logic [11:0] prev4;
    int          idx4;

    task automatic watch4();
        if (rec4 !== prev4) begin
            if (idx4 < 12) check($sformatf("ovf_out%0d", idx4), 32'(rec4), 32'(ovf_expect(idx4)));
            else           check("ovf_extra", 32'(rec4), 32'(prev4));
            idx4++;
            prev4 = rec4;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b1; ready = 1'b1; data = '0;
        v1 = 1'b0; v3 = 1'b0; v4 = 1'b0;
        step();
        step();
        // ---- reset state ----
        check("rst_rec1",  32'(rec1),  32'h0);
        check("rst_pend1", 32'(pend1), 32'h0);
        check("rst_ovf1",  32'(ovf1),  32'h0);
        check("rst_drop1", 32'(drop1), 32'h0);
        check("rst_rec4",  32'(rec4),  32'h0);
        reset = 1'b0;
        step();

        // ---- single beat: capture edge, then output one edge later ----
        v1 = 1'b1; data = 8'hA5;
        step();
        v1 = 1'b0;
        check("single_pend_cap", 32'(pend1), 32'h1);
        check("single_rec_cap",  32'(rec1),  32'h0);
        step();
        check("single_rec",      32'(rec1),  32'h1A5);
        check("single_pend_pop", 32'(pend1), 32'h0);
        step();
        step();
        check("single_stable",   32'(rec1),  32'h1A5);

        // ---- enable low or ready low: nothing captured ----
        en = 1'b0; v1 = 1'b1; data = 8'h3C;
        step();
        en = 1'b1; ready = 1'b0;
        step();
        ready = 1'b1; v1 = 1'b0;
        check("gate_pend", 32'(pend1), 32'h0);
        step();
        check("gate_rec",  32'(rec1),  32'h1A5);

        // ---- identical repeats ----
        pulse_reset();
        data = 8'h00;
        v1 = 1'b1;
        step();
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) v1 = 1'b0;
            step();
            check($sformatf("repeat%0d", i), 32'(rec1), 32'(i) << 8);
        end

        // ---- pacing with HOLD=3 (dut3 untouched since last reset) ----
        begin
            logic [11:0] pace_exp [8];
            pace_exp = '{12'h000, 12'h111, 12'h111, 12'h111,
                         12'h222, 12'h222, 12'h222, 12'h333};
            for (int i = 0; i < 8; i++) begin
                v3   = (i < 3);
                data = 8'(8'h11 * (i + 1));
                step();
                check($sformatf("pace%0d", i), 32'(rec3), 32'(pace_exp[i]));
                if (i == 2) check("pace_pend_peak", 32'(pend3), 32'h1);
            end
            v3 = 1'b0;
            check("pace_pend_end", 32'(pend3), 32'h0);
        end

        // ---- overflow: 14 back-to-back beats into dut4 ----
        prev4 = rec4;
        idx4  = 0;
        for (int i = 1; i <= 14; i++) begin
            v4   = 1'b1;
            data = 8'(i);
            step();
            watch4();
            if (i == 12) check("ovf_drop_e12", 32'(drop4), 32'h1);
            if (i == 13) check("ovf_drop_e13", 32'(drop4), 32'h2);
        end
        v4 = 1'b0;
        check("ovf_flag",     32'(ovf4),  32'h1);
        check("ovf_drop_cnt", 32'(drop4), 32'h2);
        for (int c = 0; c < 200 && idx4 < 12; c++) begin
            step();
            watch4();
        end
        check("ovf_out_count", 32'(idx4), 32'd12);
        for (int c = 0; c < 8; c++) begin
            step();
            watch4();
        end
        check("ovf_hold_last", 32'(rec4),  32'hC0E);
        check("ovf_pend_end",  32'(pend4), 32'h0);
        check("ovf_sticky",    32'(ovf4),  32'h1);

        // ---- seq wrap on dut1 ----
        pulse_reset();
        for (int i = 0; i <= 17; i++) begin
            v1   = (i < 17);
            data = 8'(i + 1);
            step();
            if (i >= 1) check($sformatf("wrap%0d", i), 32'(rec1), 32'({4'(i), 8'(i)}));
        end
        v1 = 1'b0;

        // ---- saturation, then reset mid-burst on dut4 ----
        pulse_reset();
        for (int i = 1; i <= 16; i++) begin
            v4   = 1'b1;
            data = 8'(8'h40 + i);
            step();
        end
        check("sat_drop", 32'(drop4), 32'h3);
        check("sat_ovf",  32'(ovf4),  32'h1);
        check("sat_pend", 32'(pend4), 32'h1);
        reset = 1'b1;
        data  = 8'hEE;
        step();
        reset = 1'b0;
        v4    = 1'b0;
        check("mid_rst_rec",  32'(rec4),  32'h0);
        check("mid_rst_pend", 32'(pend4), 32'h0);
        check("mid_rst_ovf",  32'(ovf4),  32'h0);
        check("mid_rst_drop", 32'(drop4), 32'h0);
        step();
        check("mid_rst_nocap", 32'(pend4), 32'h0);
        v4 = 1'b1; data = 8'h5A;
        step();
        v4 = 1'b0;
        step();
        check("mid_rst_next", 32'(rec4), 32'h15A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
